// File: rtl/dmem_arbiter.sv
// -----------------------------------------------------------------------------
// dmem_arbiter
//
// Owns the data RAM and shares its single port between the host register
// interface and the pipeline load/store stage.
//
// The host has priority. After STARVE_LIMIT consecutive host wins against a
// waiting pipeline request, the pipeline is granted for one cycle. A
// STARVE_LIMIT of 0 gives the host strict priority.
//
// Host accesses select one HOST_W lane inside a DATA_W memory word. Pipeline
// accesses always use the full word.
//
// Ports
//   clk, reset          : clock; synchronous active-high reset
//   host_req/we/addr    : host access request (single cycle per access)
//   host_lane/wdata     : lane select and write data for the host
//   host_gnt            : combinational host grant
//   host_rdata/rvalid   : registered lane read data and its one-cycle strobe
//   pipe_req/we/addr    : pipeline load/store request; only the low ADDR_W
//                         address bits are used
//   pipe_wdata          : full-word store data
//   pipe_stall          : combinational; pipeline request not granted
//   pipe_rdata/rvalid   : registered load data and its one-cycle strobe
// -----------------------------------------------------------------------------
module dmem_arbiter #(
    parameter int ADDR_W       = 8,
    parameter int DATA_W       = 64,
    parameter int HOST_W       = 32,
    parameter int LANE_W       = 1,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              host_req,
    input  logic              host_we,
    input  logic [ADDR_W-1:0] host_addr,
    input  logic [LANE_W-1:0] host_lane,
    input  logic [HOST_W-1:0] host_wdata,
    output logic              host_gnt,
    output logic [HOST_W-1:0] host_rdata,
    output logic              host_rvalid,
    input  logic              pipe_req,
    input  logic              pipe_we,
    input  logic [31:0]       pipe_addr,
    input  logic [DATA_W-1:0] pipe_wdata,
    output logic              pipe_stall,
    output logic [DATA_W-1:0] pipe_rdata,
    output logic              pipe_rvalid
);

    localparam int DEPTH    = 2 ** ADDR_W;
    localparam int LANES    = DATA_W / HOST_W;
    localparam int STREAK_W = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);

    logic [DATA_W-1:0]   mem [DEPTH];

    logic [STREAK_W-1:0] streak_reg;
    logic [STREAK_W-1:0] streak_next;
    logic                forced;
    logic                pipe_gnt;
    logic                mem_we;
    logic [ADDR_W-1:0]   mem_addr;
    logic [DATA_W-1:0]   mem_wdata;
    logic [LANES-1:0]    lane_we;

    logic [HOST_W-1:0]   host_rdata_reg;
    logic                host_rvalid_reg;
    logic [DATA_W-1:0]   pipe_rdata_reg;
    logic                pipe_rvalid_reg;

    // The upper pipeline address bits alias onto the RAM by design.
    logic unused_pipe_addr;
    assign unused_pipe_addr = &{1'b0, pipe_addr[31:ADDR_W]};

    // ---------------- arbitration ----------------
    // The streak never passes STARVE_LIMIT, because reaching it forces a
    // pipeline grant, which clears the streak.
    assign forced     = (STARVE_LIMIT != 0) && pipe_req &&
                        (streak_reg == STREAK_W'(STARVE_LIMIT));
    assign host_gnt   = host_req & ~forced;
    assign pipe_gnt   = pipe_req & (~host_req | forced);
    assign pipe_stall = pipe_req & ~pipe_gnt;

    always_comb begin
        streak_next = streak_reg;
        if (STARVE_LIMIT == 0 || !pipe_req || pipe_gnt) begin
            streak_next = '0;
        end else if (host_gnt) begin
            streak_next = streak_reg + STREAK_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            streak_reg <= '0;
        end else begin
            streak_reg <= streak_next;
        end
    end

    // ---------------- shared memory port ----------------
    assign mem_addr  = host_gnt ? host_addr : pipe_addr[ADDR_W-1:0];
    assign mem_we    = (host_gnt & host_we) | (pipe_gnt & pipe_we);
    // Host write data is replicated across all lanes. The lane enables
    // select which lane is actually written.
    assign mem_wdata = host_gnt ? {LANES{host_wdata}} : pipe_wdata;

    generate
        for (genvar gi = 0; gi < LANES; gi++) begin : g_lane_we
            assign lane_we[gi] = mem_we & ~reset &
                                 (pipe_gnt | (host_lane == LANE_W'(gi)));
        end
    endgenerate

    // RAM contents are deliberately left untouched by reset.
    always_ff @(posedge clk) begin
        for (int l = 0; l < LANES; l++) begin
            if (lane_we[l]) begin
                mem[mem_addr][l*HOST_W +: HOST_W] <= mem_wdata[l*HOST_W +: HOST_W];
            end
        end
    end

    // Each requester has its own read register. This lets each one hold its
    // last value across reads issued by the other requester.
    always_ff @(posedge clk) begin
        if (reset) begin
            host_rdata_reg  <= '0;
            host_rvalid_reg <= 1'b0;
            pipe_rdata_reg  <= '0;
            pipe_rvalid_reg <= 1'b0;
        end else begin
            host_rvalid_reg <= host_gnt & ~host_we;
            pipe_rvalid_reg <= pipe_gnt & ~pipe_we;
            if (host_gnt && !host_we) begin
                host_rdata_reg <= mem[mem_addr][host_lane*HOST_W +: HOST_W];
            end
            if (pipe_gnt && !pipe_we) begin
                pipe_rdata_reg <= mem[mem_addr];
            end
        end
    end

    assign host_rdata  = host_rdata_reg;
    assign host_rvalid = host_rvalid_reg;
    assign pipe_rdata  = pipe_rdata_reg;
    assign pipe_rvalid = pipe_rvalid_reg;

endmodule

// File: tb/tb_dmem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_dmem_arbiter
//
// Directed bench with a scoreboard.
//
// Stimulus tasks push the expected read data into per-requester queues. A
// monitor branch pops an entry whenever a read strobe appears and compares it.
//
// A second instance with STARVE_LIMIT=0 shares the inputs. It checks that
// strict host priority never lets the pipeline through.
// -----------------------------------------------------------------------------
module tb_dmem_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        host_req, host_we;
    logic [7:0]  host_addr;
    logic [0:0]  host_lane;
    logic [31:0] host_wdata;
    logic        pipe_req, pipe_we;
    logic [31:0] pipe_addr;
    logic [63:0] pipe_wdata;

    logic        host_gnt, host_rvalid, pipe_stall, pipe_rvalid;
    logic [31:0] host_rdata;
    logic [63:0] pipe_rdata;

    logic        s0_host_gnt, s0_host_rvalid, s0_pipe_stall, s0_pipe_rvalid;
    logic [31:0] s0_host_rdata;
    logic [63:0] s0_pipe_rdata;

    int errors = 0;
    int checks = 0;
    logic [31:0] host_q[$];
    logic [63:0] pipe_q[$];

    always #5 clk = ~clk;

    dmem_arbiter #(.ADDR_W(8), .DATA_W(64), .HOST_W(32), .LANE_W(1), .STARVE_LIMIT(4)) dut (
        .clk(clk), .reset(reset),
        .host_req(host_req), .host_we(host_we), .host_addr(host_addr),
        .host_lane(host_lane), .host_wdata(host_wdata), .host_gnt(host_gnt),
        .host_rdata(host_rdata), .host_rvalid(host_rvalid),
        .pipe_req(pipe_req), .pipe_we(pipe_we), .pipe_addr(pipe_addr),
        .pipe_wdata(pipe_wdata), .pipe_stall(pipe_stall),
        .pipe_rdata(pipe_rdata), .pipe_rvalid(pipe_rvalid)
    );

    dmem_arbiter #(.ADDR_W(8), .DATA_W(64), .HOST_W(32), .LANE_W(1), .STARVE_LIMIT(0)) dut_strict (
        .clk(clk), .reset(reset),
        .host_req(host_req), .host_we(host_we), .host_addr(host_addr),
        .host_lane(host_lane), .host_wdata(host_wdata), .host_gnt(s0_host_gnt),
        .host_rdata(s0_host_rdata), .host_rvalid(s0_host_rvalid),
        .pipe_req(pipe_req), .pipe_we(pipe_we), .pipe_addr(pipe_addr),
        .pipe_wdata(pipe_wdata), .pipe_stall(s0_pipe_stall),
        .pipe_rdata(s0_pipe_rdata), .pipe_rvalid(s0_pipe_rvalid)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end else begin
            $display("ok   %s: %h", name, act);
        end
    endtask

    task automatic host_op(input logic we, input logic [7:0] addr, input logic lane,
                           input logic [31:0] wd, input logic [31:0] exp);
        host_req = 1'b1; host_we = we; host_addr = addr; host_lane = lane; host_wdata = wd;
        pipe_req = 1'b0;
        @(negedge clk);
        chk("host_gnt", 64'(host_gnt), 64'd1);
        if (!we) host_q.push_back(exp);
        @(posedge clk); #1;
        host_req = 1'b0; host_we = 1'b0;
    endtask

    task automatic pipe_op(input logic we, input logic [31:0] addr,
                           input logic [63:0] wd, input logic [63:0] exp);
        pipe_req = 1'b1; pipe_we = we; pipe_addr = addr; pipe_wdata = wd;
        host_req = 1'b0;
        @(negedge clk);
        chk("pipe_stall_idle", 64'(pipe_stall), 64'd0);
        if (!we) pipe_q.push_back(exp);
        @(posedge clk); #1;
        pipe_req = 1'b0; pipe_we = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        host_req = 0; host_we = 0; host_addr = 0; host_lane = 0; host_wdata = 0;
        pipe_req = 0; pipe_we = 0; pipe_addr = 0; pipe_wdata = 0;

        fork
            // Scoreboard monitor.
            forever begin
                @(negedge clk);
                if (host_rvalid) begin
                    if (host_q.size() == 0) chk("host_rvalid_unexpected", 64'd1, 64'd0);
                    else chk("host_rdata", 64'(host_rdata), 64'(host_q.pop_front()));
                end
                if (pipe_rvalid) begin
                    if (pipe_q.size() == 0) chk("pipe_rvalid_unexpected", 64'd1, 64'd0);
                    else chk("pipe_rdata", pipe_rdata, pipe_q.pop_front());
                end
            end
        join_none

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_host_rvalid", 64'(host_rvalid), 64'd0);
        chk("rst_host_rdata",  64'(host_rdata),  64'd0);
        chk("rst_pipe_rvalid", 64'(pipe_rvalid), 64'd0);
        chk("rst_pipe_rdata",  pipe_rdata,       64'd0);
        @(posedge clk); #1;
        reset = 1'b0;

        // Lane-addressed host write and read.
        host_op(1'b1, 8'h10, 1'b0, 32'h1111_1111, '0);
        host_op(1'b1, 8'h10, 1'b1, 32'hDEAD_BEEF, '0);
        host_op(1'b0, 8'h10, 1'b1, '0, 32'hDEAD_BEEF);
        host_op(1'b0, 8'h10, 1'b0, '0, 32'h1111_1111);

        // Pipeline store through an aliased address, then load.
        pipe_op(1'b1, 32'h0000_0105, 64'h0123_4567_89AB_CDEF, '0);
        pipe_op(1'b0, 32'h0000_0005, '0, 64'h0123_4567_89AB_CDEF);

        // A host lane write merges into a word that the next pipeline load sees.
        pipe_op(1'b1, 32'h20, 64'hAAAA_AAAA_BBBB_BBBB, '0);
        host_op(1'b1, 8'h20, 1'b1, 32'hCAFE_F00D, '0);
        pipe_op(1'b0, 32'h20, '0, 64'hCAFE_F00D_BBBB_BBBB);

        // A read and a write are both issued while reset is high.
        // Neither takes effect.
        reset = 1'b1;
        host_req = 1'b1; host_we = 1'b0; host_addr = 8'h10; host_lane = 1'b1;
        @(posedge clk); #1;
        host_we = 1'b1; host_lane = 1'b0; host_wdata = 32'h9999_9999;
        @(negedge clk);
        chk("rst_rd_host_rvalid", 64'(host_rvalid), 64'd0);
        chk("rst_rd_host_rdata",  64'(host_rdata),  64'd0);
        chk("rst_rd_pipe_rdata",  pipe_rdata,       64'd0);
        @(posedge clk); #1;
        host_req = 1'b0; host_we = 1'b0;
        reset = 1'b0;
        host_op(1'b0, 8'h10, 1'b1, '0, 32'hDEAD_BEEF);
        host_op(1'b0, 8'h10, 1'b0, '0, 32'h1111_1111);

        // Both requesters contend continuously for 20 cycles.
        host_req = 1'b1; host_we = 1'b0; host_addr = 8'h10; host_lane = 1'b1;
        pipe_req = 1'b1; pipe_we = 1'b0; pipe_addr = 32'h05;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk($sformatf("cont_host_gnt[%0d]", i), 64'(host_gnt), 64'((i % 5) != 4));
            chk($sformatf("cont_pipe_stall[%0d]", i), 64'(pipe_stall), 64'((i % 5) != 4));
            chk($sformatf("strict_stall[%0d]", i), 64'(s0_pipe_stall), 64'd1);
            chk($sformatf("strict_rvalid[%0d]", i), 64'(s0_pipe_rvalid), 64'd0);
            if ((i % 5) != 4) host_q.push_back(32'hDEAD_BEEF);
            else pipe_q.push_back(64'h0123_4567_89AB_CDEF);
            @(posedge clk); #1;
        end
        host_req = 1'b0; pipe_req = 1'b0;
        @(negedge clk);
        chk("strict_rvalid_last", 64'(s0_pipe_rvalid), 64'd0);

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("host_q_drained", 64'(host_q.size()), 64'd0);
        chk("pipe_q_drained", 64'(pipe_q.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
